// File: rtl/mskaes_128bits_round_ctrl_pkg.sv
// Shared definitions for the masked AES-128 round sequencer.
//   state_e   : sequencer FSM state encoding
//   NROUNDS   : number of AES-128 rounds
//   ROUND_W   : width of the round index
//   RCON_INIT : RCON value used by round 1
package mskaes_128bits_round_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned NROUNDS   = 10;
    localparam int unsigned ROUND_W   = 4;
    localparam int unsigned RCON_W    = 8;
    localparam logic [RCON_W-1:0] RCON_INIT = 8'h01;

    // Encryption in progress: input shares loaded or rounds running.
    function automatic logic is_busy(input state_e st);
        return (st == ST_INIT) || (st == ST_ROUND);
    endfunction

endpackage

// File: rtl/mskaes_128bits_round_ctrl.sv
// Round sequencer for the 128-bit masked AES core.
// Drives the RCON delay pipeline, times the rounds against the S-box
// pipeline depth and wraps one encryption in valid/ready handshakes.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid / in_ready        : upstream handshake (new plaintext/key shares)
//   out_valid / out_ready      : downstream handshake (ciphertext shares)
//   rcon_to_pipe               : current RCON into the RCON delay pipeline
//   rcon_from_pipe             : xtime(RCON) returned by that pipeline
//   init                       : load input shares and apply AddRoundKey 0
//   round_en                   : state/key registers capture the round result
//   last_round                 : round 10, MixColumns bypassed
//   round_idx                  : current round 1..10, 0 outside rounds
//   busy                       : INIT or ROUND in progress
module mskaes_128bits_round_ctrl
    import mskaes_128bits_round_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RCON_W-1:0]   rcon_to_pipe,
    input  logic [RCON_W-1:0]   rcon_from_pipe,
    output logic                init,
    output logic                round_en,
    output logic                last_round,
    output logic [ROUND_W-1:0]  round_idx,
    output logic                busy
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [ROUND_W-1:0] IDX_LAST = ROUND_W'(NROUNDS);
    localparam logic [ROUND_W-1:0] IDX_FIRST = ROUND_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RCON_W-1:0]   rcon_q, rcon_d;
    logic [ROUND_W-1:0]  idx_q, idx_d;

    logic in_ready_q,   in_ready_d;
    logic out_valid_q,  out_valid_d;
    logic init_q,       init_d;
    logic round_en_q,   round_en_d;
    logic last_round_q, last_round_d;
    logic busy_q,       busy_d;

    // Next-state, counters and RCON register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcon_d  = rcon_q;
        idx_d   = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (in_valid) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                rcon_d  = RCON_INIT;
                idx_d   = IDX_FIRST;
                cnt_d   = '0;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (cnt_q == CNT_LAST) begin
                    // Round boundary: pipeline output is xtime of the current RCON.
                    cnt_d  = '0;
                    rcon_d = rcon_from_pipe;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_FIRST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are precomputed from next state so they leave the block registered.
    always_comb begin
        in_ready_d   = (state_d == ST_IDLE);
        out_valid_d  = (state_d == ST_DONE);
        init_d       = (state_d == ST_INIT);
        round_en_d   = (state_d == ST_ROUND) && (cnt_d == CNT_LAST);
        last_round_d = (state_d == ST_ROUND) && (idx_d == IDX_LAST);
        busy_d       = is_busy(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rcon_q       <= '0;
            idx_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            init_q       <= 1'b0;
            round_en_q   <= 1'b0;
            last_round_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rcon_q       <= rcon_d;
            idx_q        <= idx_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            init_q       <= init_d;
            round_en_q   <= round_en_d;
            last_round_q <= last_round_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign init         = init_q;
    assign round_en     = round_en_q;
    assign last_round   = last_round_q;
    assign busy         = busy_q;
    assign round_idx    = idx_q;
    assign rcon_to_pipe = rcon_q;

endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
// Bench for the masked AES round sequencer: two instances (LATENCY=6 and
// LATENCY=2) share stimulus, each closed through an RCON delay pipeline of
// LATENCY-1 xtime stages, and are checked against a transaction-level model.
module tb_mskaes_128bits_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    // Instance A: LATENCY=6
    logic       ir_a, ov_a, init_a, re_a, lr_a, busy_a;
    logic [3:0] idx_a;
    logic [7:0] rto_a, rfrom_a;
    // Instance B: LATENCY=2
    logic       ir_b, ov_b, init_b, re_b, lr_b, busy_b;
    logic [3:0] idx_b;
    logic [7:0] rto_b, rfrom_b;

    mskaes_128bits_round_ctrl #(.LATENCY(6)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a),
        .out_valid(ov_a), .out_ready(out_ready), .rcon_to_pipe(rto_a),
        .rcon_from_pipe(rfrom_a), .init(init_a), .round_en(re_a),
        .last_round(lr_a), .round_idx(idx_a), .busy(busy_a)
    );

    mskaes_128bits_round_ctrl #(.LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b),
        .out_valid(ov_b), .out_ready(out_ready), .rcon_to_pipe(rto_b),
        .rcon_from_pipe(rfrom_b), .init(init_b), .round_en(re_b),
        .last_round(lr_b), .round_idx(idx_b), .busy(busy_b)
    );

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // RCON delay pipelines (not reset, so stale contents must be flushed).
    logic [7:0] pa [5];
    logic [7:0] pb;
    always @(posedge clk) begin
        pa[0] <= xt(rto_a);
        for (int i = 1; i < 5; i++) pa[i] <= pa[i-1];
        pb <= xt(rto_b);
    end
    assign rfrom_a = pa[4];
    assign rfrom_b = pb;

    // Observation vector: {in_ready,out_valid,init,round_en,last_round,busy,round_idx,rcon}
    logic [17:0] obs_a, obs_b;
    assign obs_a = {ir_a, ov_a, init_a, re_a, lr_a, busy_a, idx_a, rto_a};
    assign obs_b = {ir_b, ov_b, init_b, re_b, lr_b, busy_b, idx_b, rto_b};

    function automatic logic [17:0] mk(input logic ir, input logic ov, input logic in,
                                       input logic re, input logic lr, input logic bz,
                                       input int idx, input logic [7:0] rc);
        return {ir, ov, in, re, lr, bz, 4'(idx), rc};
    endfunction

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 busy (k cycles since accept), 2 done.
    logic [7:0] tab [10];
    int lat [2] = '{6, 2};
    int ph [2] = '{0, 0};
    int kk [2] = '{0, 0};
    logic [7:0] lastr [2] = '{8'h00, 8'h00};

    function automatic logic [17:0] exp_vec(input int d);
        int r;
        case (ph[d])
            0: return mk(1, 0, 0, 0, 0, 0, 0, lastr[d]);
            1: begin
                if (kk[d] == 1) return mk(0, 0, 1, 0, 0, 1, 0, lastr[d]);
                r = (kk[d] - 2) / lat[d] + 1;
                return mk(0, 0, 0, ((kk[d] - 1) % lat[d]) == 0, r == 10, 1, r, tab[r-1]);
            end
            default: return mk(0, 1, 0, 0, 0, 0, 0, xt(tab[9]));
        endcase
    endfunction

    task automatic advance(input int d);
        if (rst) begin
            ph[d] = 0; kk[d] = 0; lastr[d] = 8'h00;
        end else begin
            case (ph[d])
                0: if (in_valid) begin ph[d] = 1; kk[d] = 1; end
                1: begin
                    if (kk[d] == 1 + 10 * lat[d]) begin
                        ph[d] = 2; lastr[d] = xt(tab[9]);
                    end else begin
                        kk[d]++;
                    end
                end
                default: if (out_ready) ph[d] = 0;
            endcase
        end
    endtask

    // One clock: update model on the edge, sample 1 time unit later.
    task automatic step();
        advance(0);
        advance(1);
        @(posedge clk);
        #1;
        cyc++;
        chk("model_lat6", 32'(obs_a), 32'(exp_vec(0)));
        chk("model_lat2", 32'(obs_b), 32'(exp_vec(1)));
    endtask

    typedef struct {
        int         dut;
        int         k;
        logic [17:0] exp;
    } vec_t;
    vec_t tbl [15];

    logic [7:0] rcon_ref [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    logic [17:0] rst_vec;

    // Run one fresh encryption from IDLE and check the RCON seen at every round_en.
    task automatic rcon_run(input string nm);
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        out_ready = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (re_a) qa.push_back(rto_a);
            if (re_b) qb.push_back(rto_b);
        end
        chk({nm, "_cnt6"}, 32'(qa.size()), 32'd10);
        chk({nm, "_cnt2"}, 32'(qb.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < qa.size()) chk({nm, "_rcon6"}, 32'(qa[i]), 32'(rcon_ref[i]));
            if (i < qb.size()) chk({nm, "_rcon2"}, 32'(qb[i]), 32'(rcon_ref[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        tab[0] = 8'h01;
        for (int i = 1; i < 10; i++) tab[i] = xt(tab[i-1]);
        rst_vec = mk(1, 0, 0, 0, 0, 0, 0, 8'h00);

        tbl[0]  = '{0, 1,  mk(0,0,1,0,0,1, 0,8'h00)};
        tbl[1]  = '{0, 2,  mk(0,0,0,0,0,1, 1,8'h01)};
        tbl[2]  = '{0, 6,  mk(0,0,0,0,0,1, 1,8'h01)};
        tbl[3]  = '{0, 7,  mk(0,0,0,1,0,1, 1,8'h01)};
        tbl[4]  = '{0, 8,  mk(0,0,0,0,0,1, 2,8'h02)};
        tbl[5]  = '{0, 13, mk(0,0,0,1,0,1, 2,8'h02)};
        tbl[6]  = '{0, 55, mk(0,0,0,1,0,1, 9,8'h1B)};
        tbl[7]  = '{0, 56, mk(0,0,0,0,1,1,10,8'h36)};
        tbl[8]  = '{0, 61, mk(0,0,0,1,1,1,10,8'h36)};
        tbl[9]  = '{0, 62, mk(0,1,0,0,0,0, 0,8'h6C)};
        tbl[10] = '{0, 70, mk(0,1,0,0,0,0, 0,8'h6C)};
        tbl[11] = '{1, 3,  mk(0,0,0,1,0,1, 1,8'h01)};
        tbl[12] = '{1, 21, mk(0,0,0,1,1,1,10,8'h36)};
        tbl[13] = '{1, 22, mk(0,1,0,0,0,0, 0,8'h6C)};
        tbl[14] = '{1, 5,  mk(0,0,0,1,0,1, 2,8'h02)};

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_lat6", 32'(obs_a), 32'(rst_vec));
        chk("reset_lat2", 32'(obs_b), 32'(rst_vec));

        // Single encryption against the timing table, out_ready held low.
        in_valid = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 1) in_valid = 1'b0;
            for (int j = 0; j < 15; j++) begin
                if (tbl[j].k == k)
                    chk(tbl[j].dut == 0 ? "table_lat6" : "table_lat2",
                        32'(tbl[j].dut == 0 ? obs_a : obs_b), 32'(tbl[j].exp));
            end
        end

        // Backpressure in DONE with a pending request.
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_in_ready", 32'(ir_a), 32'd0);
            chk("bp_out_valid", 32'(ov_a), 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("rel_in_ready", 32'(ir_a), 32'd1);
        chk("rel_no_init", 32'(init_a), 32'd0);
        step();
        chk("rel_accept", 32'(init_a), 32'd1);

        // Back-to-back with in_valid and out_ready tied high.
        begin
            int last_a = 0, last_b = 0, en_a = 0, en_b = 0, n_a = 0, n_b = 0;
            for (int c = 1; c <= 190; c++) begin
                step();
                if (re_a) en_a++;
                if (re_b) en_b++;
                if (init_a) begin
                    chk("b2b_interval6", 32'(c - last_a), 32'd63);
                    chk("b2b_rounds6", 32'(en_a), 32'd10);
                    last_a = c; en_a = 0; n_a++;
                end
                if (init_b) begin
                    chk("b2b_interval2", 32'(c - last_b), 32'd23);
                    chk("b2b_rounds2", 32'(en_b), 32'd10);
                    last_b = c; en_b = 0; n_b++;
                end
            end
            chk("b2b_count6", 32'(n_a), 32'd3);
            chk("b2b_count2", 32'(n_b), 32'd8);
        end

        // Reset mid-round (round 4, cnt 3 on the LATENCY=6 instance).
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 2; k <= 23; k++) step();
        chk("mid_round_idx", 32'(idx_a), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset6", 32'(obs_a), 32'(rst_vec));
        chk("mid_reset2", 32'(obs_b), 32'(rst_vec));
        rcon_run("flush");

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) == 0;
            rst       = ($urandom % 300) == 0;
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 80; i++) step();
        rcon_run("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
